// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection.
//
// A load sitting in EX whose destination is read by the instruction in ID
// forces a one-cycle stall: stall_id holds PC and IF/ID while a bubble is
// inserted into EX. The bubble clears ex_valid, so the held instruction
// advances on the following edge. A branch/jump redirect (ex_flush) kills
// the ID slot and takes priority over the stall.
//
// Optional feature macro: ID_EX_WB_BYPASS_EN
//   When defined, a writeback committing in the same cycle as capture is
//   forwarded into ex_rs1_data / ex_rs2_data (per operand, x0 excluded).
//   When undefined, the register-file read data is captured unchanged.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   id_*                      decoded instruction fields from the ID stage
//   ex_flush                  redirect: load a bubble into EX
//   wb_reg_write/wt_addr/data writeback port (used only for bypass)
//   stall_id                  combinational stall request to IF/ID
//   ex_*                      registered copies of the ID fields
//   stall_count               saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      id_rd_addr,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [11:0]     id_ctrl,
  input  logic            ex_flush,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_wt_addr,
  input  logic [XLEN-1:0] wb_wt_data,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [11:0]     ex_ctrl,
  output logic [31:0]     stall_count
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic            rs1_match_s;
  logic            rs2_match_s;
  logic            hazard_s;
  logic            bubble_s;
  logic [XLEN-1:0] rs1_next_s;
  logic [XLEN-1:0] rs2_next_s;

  // Load-use detection against the instruction currently held in EX.
  // ex_valid is a register, so reset removes the hazard immediately.
  always_comb begin
    rs1_match_s = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    rs2_match_s = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    hazard_s    = id_valid && ex_valid && ex_mem_read &&
                  (ex_rd_addr != 5'd0) && (rs1_match_s || rs2_match_s);
    bubble_s    = ex_flush || hazard_s;
  end

  // A flush already discards the ID instruction, so no stall is needed then.
  assign stall_id = hazard_s & ~ex_flush;

  // Operand data to capture, optionally forwarded from writeback.
  always_comb begin
    rs1_next_s = id_rs1_data;
    rs2_next_s = id_rs2_data;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && (wb_wt_addr != 5'd0) && (wb_wt_addr == id_rs1_addr)) begin
      rs1_next_s = wb_wt_data;
    end else begin
      rs1_next_s = id_rs1_data;
    end
    if (wb_reg_write && (wb_wt_addr != 5'd0) && (wb_wt_addr == id_rs2_addr)) begin
      rs2_next_s = wb_wt_data;
    end else begin
      rs2_next_s = id_rs2_data;
    end
`endif
  end

`ifndef ID_EX_WB_BYPASS_EN
  // Writeback port only feeds the bypass path; fold it away otherwise.
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_reg_write, wb_wt_addr, wb_wt_data};
`endif

  // ID/EX pipeline register: bubble on flush or load-use, else capture ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= {XLEN{1'b0}};
      ex_imm       <= {XLEN{1'b0}};
      ex_rs1_data  <= {XLEN{1'b0}};
      ex_rs2_data  <= {XLEN{1'b0}};
      ex_rs1_addr  <= 5'd0;
      ex_rs2_addr  <= 5'd0;
      ex_rd_addr   <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= 12'd0;
    end else if (bubble_s) begin
      ex_valid     <= 1'b0;
      ex_pc        <= {XLEN{1'b0}};
      ex_imm       <= {XLEN{1'b0}};
      ex_rs1_data  <= {XLEN{1'b0}};
      ex_rs2_data  <= {XLEN{1'b0}};
      ex_rs1_addr  <= 5'd0;
      ex_rs2_addr  <= 5'd0;
      ex_rd_addr   <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= 12'd0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1_data  <= rs1_next_s;
      ex_rs2_data  <= rs2_next_s;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      // An empty ID slot must never write a register or access memory.
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_ctrl      <= id_ctrl;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= 32'd0;
    end else if (stall_id && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 32'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = 32'd0;
  logic [4:0]  id_rs1_addr = 5'd0;
  logic [4:0]  id_rs2_addr = 5'd0;
  logic [31:0] id_rs1_data = 32'd0;
  logic [31:0] id_rs2_data = 32'd0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  id_rd_addr = 5'd0;
  logic [31:0] id_imm = 32'd0;
  logic        id_reg_write = 1'b0;
  logic        id_mem_read = 1'b0;
  logic [11:0] id_ctrl = 12'd0;
  logic        ex_flush = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_wt_addr = 5'd0;
  logic [31:0] wb_wt_data = 32'd0;
  logic        stall_id;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_reg_write, ex_mem_read;
  logic [11:0] ex_ctrl;
  logic [31:0] stall_count;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_addr(id_rd_addr), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .ex_flush(ex_flush),
    .wb_reg_write(wb_reg_write), .wb_wt_addr(wb_wt_addr), .wb_wt_data(wb_wt_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what the EX slot should hold, and the expected stall total.
  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rda;
    logic        rw, mr;
    logic [11:0] ctrl;
  } slot_t;

  slot_t       m;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0; s.pc = 32'd0; s.imm = 32'd0; s.rs1d = 32'd0; s.rs2d = 32'd0;
    s.rs1a = 5'd0; s.rs2a = 5'd0; s.rda = 5'd0; s.rw = 1'b0; s.mr = 1'b0;
    s.ctrl = 12'd0;
    return s;
  endfunction

  // Does the ID instruction read a register that the load in EX has yet to produce?
  function automatic logic model_load_use();
    logic reads_rd;
    if (!(id_valid && m.valid && m.mr) || m.rda == 5'd0) return 1'b0;
    reads_rd = (id_uses_rs1 && id_rs1_addr == m.rda) || (id_uses_rs2 && id_rs2_addr == m.rda);
    return reads_rd;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_reg_write && wb_wt_addr != 5'd0 && wb_wt_addr == a) return wb_wt_data;
`endif
    return d;
  endfunction

  function automatic logic model_stall();
    return model_load_use() && !ex_flush;
  endfunction

  // One clock edge seen from the model's point of view.
  task automatic model_edge();
    slot_t n;
    logic  stall;
    stall = model_stall();
    n = empty_slot();
    if (stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (!ex_flush && !model_load_use()) begin
      n.valid = id_valid;  n.pc = id_pc;  n.imm = id_imm;
      n.rs1d = operand(id_rs1_addr, id_rs1_data);
      n.rs2d = operand(id_rs2_addr, id_rs2_data);
      n.rs1a = id_rs1_addr; n.rs2a = id_rs2_addr; n.rda = id_rd_addr;
      n.rw = id_valid && id_reg_write;
      n.mr = id_valid && id_mem_read;
      n.ctrl = id_ctrl;
    end
    m = n;
  endtask

  task automatic check_outputs(input string ph);
    check_eq({ph, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, m.valid});
    check_eq({ph, ".ex_pc"},        ex_pc,                 m.pc);
    check_eq({ph, ".ex_imm"},       ex_imm,                m.imm);
    check_eq({ph, ".ex_rs1_data"},  ex_rs1_data,           m.rs1d);
    check_eq({ph, ".ex_rs2_data"},  ex_rs2_data,           m.rs2d);
    check_eq({ph, ".ex_rs1_addr"},  {27'd0, ex_rs1_addr},  {27'd0, m.rs1a});
    check_eq({ph, ".ex_rs2_addr"},  {27'd0, ex_rs2_addr},  {27'd0, m.rs2a});
    check_eq({ph, ".ex_rd_addr"},   {27'd0, ex_rd_addr},   {27'd0, m.rda});
    check_eq({ph, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
    check_eq({ph, ".ex_mem_read"},  {31'd0, ex_mem_read},  {31'd0, m.mr});
    check_eq({ph, ".ex_ctrl"},      {20'd0, ex_ctrl},      {20'd0, m.ctrl});
    check_eq({ph, ".stall_count"},  stall_count,           m_cnt);
  endtask

  // Inputs are already applied; check stall, clock once, check EX slot.
  task automatic step(input string ph);
    #1;
    check_eq({ph, ".stall_id"}, {31'd0, stall_id}, {31'd0, model_stall()});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ph);
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr;
    id_pc = $urandom; id_imm = $urandom;
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_ctrl = 12'($urandom);
  endtask

  task automatic rand_inputs();
    issue(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    ex_flush     = ($urandom_range(0, 9) == 0);
    wb_reg_write = 1'($urandom);
    wb_wt_addr   = 5'($urandom_range(0, 7));
    wb_wt_data   = $urandom;
  endtask

  task automatic quiet_side();
    ex_flush = 1'b0; wb_reg_write = 1'b0; wb_wt_addr = 5'd0; wb_wt_data = 32'd0;
  endtask

  logic [31:0] cnt_before;
  logic [31:0] exp_rs2;

  initial begin
    m = empty_slot();
    m_cnt = 32'd0;

    // Asynchronous reset with no clock edge in between
    #1 rst = 1'b0;
    #2;
    check_outputs("reset");
    check_eq("reset.stall_id", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load x5 then dependent read of x5 via rs1
    quiet_side();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("ld_x5");
    issue(1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    cnt_before = m_cnt;
    step("ld_use");
    check_eq("ld_use.bubble", {31'd0, ex_valid}, 32'd0);
    check_eq("ld_use.count", stall_count, cnt_before + 32'd1);
    step("ld_use_adv");
    check_eq("ld_use_adv.valid", {31'd0, ex_valid}, 32'd1);
    check_eq("ld_use_adv.rd", {27'd0, ex_rd_addr}, 32'd6);

    // Same read but uses_rs1=0: no stall
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("ld_x5b");
    issue(1'b1, 5'd5, 5'd3, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
    cnt_before = m_cnt;
    step("no_use");
    check_eq("no_use.valid", {31'd0, ex_valid}, 32'd1);
    check_eq("no_use.count", stall_count, cnt_before);

    // Load to x0 never creates a hazard
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step("ld_x0");
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step("x0_use");
    check_eq("x0_use.valid", {31'd0, ex_valid}, 32'd1);

    // Hazard plus flush in the same cycle
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("ld_x5c");
    issue(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_flush = 1'b1;
    cnt_before = m_cnt;
    step("flush_hz");
    check_eq("flush_hz.valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_hz.count", stall_count, cnt_before);
    ex_flush = 1'b0;

    // Writeback bypass on rs2, then x0 writeback which must never forward
    issue(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    id_rs2_data = 32'h0000_0001;
    wb_reg_write = 1'b1; wb_wt_addr = 5'd7; wb_wt_data = 32'hDEAD_BEEF;
`ifdef ID_EX_WB_BYPASS_EN
    exp_rs2 = 32'hDEAD_BEEF;
`else
    exp_rs2 = 32'h0000_0001;
`endif
    step("wb_x7");
    check_eq("wb_x7.rs2", ex_rs2_data, exp_rs2);
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    id_rs1_data = 32'h0000_0011; id_rs2_data = 32'h0000_0022;
    wb_reg_write = 1'b1; wb_wt_addr = 5'd0; wb_wt_data = 32'hDEAD_BEEF;
    step("wb_x0");
    check_eq("wb_x0.rs1", ex_rs1_data, 32'h0000_0011);
    check_eq("wb_x0.rs2", ex_rs2_data, 32'h0000_0022);
    quiet_side();

    // Empty ID slot never carries write/load control
    issue(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
    step("bubble_id");
    check_eq("bubble_id.ctl", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);

    // Reset asserted in the middle of a stall
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step("ld_x5d");
    issue(1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check_eq("pre_rst.stall_id", {31'd0, stall_id}, 32'd1);
    rst = 1'b0;
    #1;
    m = empty_slot();
    m_cnt = 32'd0;
    check_outputs("mid_rst");
    check_eq("mid_rst.stall_id", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst");
    check_eq("post_rst.valid", {31'd0, ex_valid}, 32'd1);

    // Saturation of the stall counter
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    force dut.stall_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stall_count;
    m = empty_slot();
    m_cnt = 32'hFFFF_FFFE;
    #1;
    check_eq("sat.preload", stall_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
      step("sat_ld");
      issue(1'b1, 5'd2, 5'd4, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      step("sat_stall");
      step("sat_adv");
    end
    check_eq("sat.final", stall_count, 32'hFFFF_FFFF);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
